// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the block-RAM port arbiter:
//   - bram_state_t : controller state encoding (ST_INIT clears, ST_RUN serves)
//   - PORT0/PORT1  : port index constants used by the grant bookkeeping
//   - WE_READ/WE_BOTH : byte-enable codes for "read" and "write both lanes"
// ---------------------------------------------------------------------------
package bram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bram_state_t;

    localparam logic       PORT0   = 1'b0;
    localparam logic       PORT1   = 1'b1;

    localparam logic [1:0] WE_READ = 2'b00;
    localparam logic [1:0] WE_BOTH = 2'b11;

endpackage : bram_pkg

// File: rtl/bram_sp_bytewe.sv
// ---------------------------------------------------------------------------
// bram_sp_bytewe
// Single-port RAM with two byte lanes, per-lane write enable and a registered
// read output in no-change mode: the output register only loads on a read
// (en with we == 2'b00) and keeps its value across writes and idle cycles.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (output register only)
//   i_en           : access enable
//   i_we[1:0]      : lane write enables (bit1 high lane, bit0 low lane)
//   i_addr         : word address
//   i_din          : write data (2*DI_WIDTH)
//   o_dout         : registered read data (2*DI_WIDTH)
// ---------------------------------------------------------------------------
module bram_sp_bytewe
    import bram_pkg::*;
#(
    parameter int SIZE      = 512,
    parameter int ADD_WIDTH = 9,
    parameter int DI_WIDTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [1:0]              i_we,
    input  logic [ADD_WIDTH-1:0]    i_addr,
    input  logic [2*DI_WIDTH-1:0]   i_din,
    output logic [2*DI_WIDTH-1:0]   o_dout
);

    logic [2*DI_WIDTH-1:0] r_mem [0:SIZE-1];
    logic [2*DI_WIDTH-1:0] r_dout;

    // Storage array: each lane is written independently so unselected lanes keep their value.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we[0]) begin
            r_mem[i_addr][DI_WIDTH-1:0] <= i_din[DI_WIDTH-1:0];
        end
        if (i_en && i_we[1]) begin
            r_mem[i_addr][2*DI_WIDTH-1:DI_WIDTH] <= i_din[2*DI_WIDTH-1:DI_WIDTH];
        end
    end

    // Output register: loads only on reads, holds on writes (no-change mode).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= {(2*DI_WIDTH){1'b0}};
        end else if (i_en && (i_we == WE_READ)) begin
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule : bram_sp_bytewe

// File: rtl/blockram_port_arbiter.sv
// ---------------------------------------------------------------------------
// blockram_port_arbiter
// Two request ports sharing one single-port byte-writable RAM. After reset the
// controller clears every word (INIT), then arbitrates one access per cycle
// (RUN). Reads answer one cycle after acceptance with a one-cycle rvalid;
// rdata holds its last value otherwise.
//
// Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN
//   defined   : on contention the port not granted last wins
//   undefined : on contention port 0 always wins
//
// Ports (n = 0,1):
//   CLK, RST_N         : clock, async active-low reset
//   pn_valid/pn_ready  : request handshake (ready is combinational)
//   pn_we[1:0]         : lane write enables, 2'b00 = read
//   pn_addr, pn_wdata  : word address and write data
//   pn_rvalid/pn_rdata : read response
//   init_done          : high once the power-up clear has completed
// ---------------------------------------------------------------------------
module blockram_port_arbiter
    import bram_pkg::*;
#(
    parameter int SIZE      = 512,
    parameter int ADD_WIDTH = 9,
    parameter int DI_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    p0_valid,
    output logic                    p0_ready,
    input  logic [1:0]              p0_we,
    input  logic [ADD_WIDTH-1:0]    p0_addr,
    input  logic [2*DI_WIDTH-1:0]   p0_wdata,
    output logic                    p0_rvalid,
    output logic [2*DI_WIDTH-1:0]   p0_rdata,
    input  logic                    p1_valid,
    output logic                    p1_ready,
    input  logic [1:0]              p1_we,
    input  logic [ADD_WIDTH-1:0]    p1_addr,
    input  logic [2*DI_WIDTH-1:0]   p1_wdata,
    output logic                    p1_rvalid,
    output logic [2*DI_WIDTH-1:0]   p1_rdata,
    output logic                    init_done
);

    bram_state_t                r_state;
    bram_state_t                w_state_nxt;
    logic [ADD_WIDTH-1:0]       r_cnt;
    logic                       w_cnt_last;
    logic                       r_init_done;
    logic                       r_p0_rvalid;
    logic                       r_p1_rvalid;
    logic [2*DI_WIDTH-1:0]      r_p0_rdata;
    logic [2*DI_WIDTH-1:0]      r_p1_rdata;

    logic                       w_prefer0;
    logic                       w_grant0;
    logic                       w_grant1;

    logic                       w_ram_en;
    logic [1:0]                 w_ram_we;
    logic [ADD_WIDTH-1:0]       w_ram_addr;
    logic [2*DI_WIDTH-1:0]      w_ram_din;
    logic [2*DI_WIDTH-1:0]      w_ram_dout;

    assign w_cnt_last = (r_cnt == ADD_WIDTH'(SIZE - 1));

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic                       r_last_grant;

    // Port 0 wins a tie only when port 1 took the previous accepted transfer.
    assign w_prefer0 = (r_last_grant == PORT1);

    // Last-grant bookkeeping moves only on an accepted transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_grant <= PORT1;
        end else if (w_grant0) begin
            r_last_grant <= PORT0;
        end else if (w_grant1) begin
            r_last_grant <= PORT1;
        end
    end
`else
    assign w_prefer0 = 1'b1;
`endif

    // At most one grant: a lone requester wins immediately, a tie goes to w_prefer0.
    assign w_grant0 = (r_state == ST_RUN) & p0_valid & (~p1_valid | w_prefer0);
    assign w_grant1 = (r_state == ST_RUN) & p1_valid & (~p0_valid | ~w_prefer0);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and RAM control: INIT sweeps zeros, RUN routes the granted port.
    always_comb begin
        w_state_nxt = r_state;
        p0_ready    = 1'b0;
        p1_ready    = 1'b0;
        w_ram_en    = 1'b0;
        w_ram_we    = WE_READ;
        w_ram_addr  = {ADD_WIDTH{1'b0}};
        w_ram_din   = {(2*DI_WIDTH){1'b0}};
        case (r_state)
            ST_INIT: begin
                w_ram_en   = 1'b1;
                w_ram_we   = WE_BOTH;
                w_ram_addr = r_cnt;
                w_ram_din  = {(2*DI_WIDTH){1'b0}};
                if (w_cnt_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                p0_ready    = w_grant0;
                p1_ready    = w_grant1;
                if (w_grant1) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = p1_we;
                    w_ram_addr = p1_addr;
                    w_ram_din  = p1_wdata;
                end else if (w_grant0) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = p0_we;
                    w_ram_addr = p0_addr;
                    w_ram_din  = p0_wdata;
                end else begin
                    w_ram_en   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Clear-address counter; it stops at the last word so RUN starts from a known value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= {ADD_WIDTH{1'b0}};
        end else if ((r_state == ST_INIT) && !w_cnt_last) begin
            r_cnt <= r_cnt + ADD_WIDTH'(1);
        end
    end

    // init_done rises the cycle after RUN is entered and is sticky until reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_init_done <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_init_done <= 1'b1;
        end
    end

    // Read-response flags: one cycle per accepted read, writes produce none.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
        end else begin
            r_p0_rvalid <= w_grant0 & (p0_we == WE_READ);
            r_p1_rvalid <= w_grant1 & (p1_we == WE_READ);
        end
    end

    // Capture each port's response so its rdata stays put once the shared RAM output moves on.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p0_rdata <= {(2*DI_WIDTH){1'b0}};
            r_p1_rdata <= {(2*DI_WIDTH){1'b0}};
        end else begin
            if (r_p0_rvalid) begin
                r_p0_rdata <= w_ram_dout;
            end
            if (r_p1_rvalid) begin
                r_p1_rdata <= w_ram_dout;
            end
        end
    end

    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_rdata  = r_p0_rvalid ? w_ram_dout : r_p0_rdata;
    assign p1_rdata  = r_p1_rvalid ? w_ram_dout : r_p1_rdata;
    assign init_done = r_init_done;

    bram_sp_bytewe #(
        .SIZE      (SIZE),
        .ADD_WIDTH (ADD_WIDTH),
        .DI_WIDTH  (DI_WIDTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_din   (w_ram_din),
        .o_dout  (w_ram_dout)
    );

endmodule : blockram_port_arbiter

// File: tb/tb_blockram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_blockram_port_arbiter
// Directed bench for blockram_port_arbiter at default parameters. Inputs are
// driven on the falling edge; outputs are sampled 1 time unit after an edge.
// Expectations under contention follow BRAM_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_blockram_port_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [1:0]  p0_we, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_rvalid, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic        init_done;

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic rr_mode;
    logic exp0;

    blockram_port_arbiter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .init_done (init_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after RST_N rises: counts edges until init_done, with port 0
    // requesting during the first cycles to confirm no grant happens in INIT.
    task automatic wait_init(output int n);
        n = 0;
        p0_we = 2'b00; p0_addr = 9'h000; p0_valid = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("init_no_ready", {31'd0, p0_ready}, 32'd0);
        p0_valid = 1'b0;
        while (!init_done && n < 1000) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    // Single-port transfer: drive at negedge, expect same-cycle grant, return 1 after acceptance edge.
    task automatic op(input int port, input logic [1:0] we, input logic [8:0] addr, input logic [15:0] wd);
        @(negedge CLK);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_valid = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_valid = 1'b1;
        end
        #1;
        if (port == 0) chk("ready_p0", {31'd0, p0_ready}, 32'd1);
        else           chk("ready_p1", {31'd0, p1_ready}, 32'd1);
        @(posedge CLK); #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    initial begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        RST_N = 1'b0;
        p0_valid = 1'b0; p0_we = 2'b00; p0_addr = 9'h000; p0_wdata = 16'h0000;
        p1_valid = 1'b0; p1_we = 2'b00; p1_addr = 9'h000; p1_wdata = 16'h0000;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_p0_ready",  {31'd0, p0_ready},  32'd0);
        chk("rst_p1_ready",  {31'd0, p1_ready},  32'd0);
        chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        chk("rst_p0_rdata",  {16'd0, p0_rdata},  32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        // Power-up clear latency: SIZE+1 = 513 edges
        @(negedge CLK);
        RST_N = 1'b1;
        wait_init(cyc);
        chk("init_latency", cyc, 32'd513);
        op(0, 2'b00, 9'h000, 16'h0000);
        chk("rd000_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("rd000_rdata",  {16'd0, p0_rdata},  32'h0000);
        op(1, 2'b00, 9'h1FF, 16'h0000);
        chk("rd1ff_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("rd1ff_rdata",  {16'd0, p1_rdata},  32'h0000);

        // Byte-lane writes then read of the same address
        op(0, 2'b11, 9'h010, 16'h1234);
        chk("wr_full_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
        op(0, 2'b01, 9'h010, 16'hABCD);
        chk("wr_lo_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("rdata_hold_on_wr", {16'd0, p0_rdata}, 32'h0000);
        op(0, 2'b00, 9'h010, 16'h0000);
        chk("lane_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("lane_rdata",  {16'd0, p0_rdata},  32'h12CD);
        @(posedge CLK); #1;
        chk("rvalid_one_cycle", {31'd0, p0_rvalid}, 32'd0);
        chk("rdata_hold_idle",  {16'd0, p0_rdata},  32'h12CD);

        // Back-to-back reads on port 1
        op(1, 2'b11, 9'h020, 16'h0001);
        op(1, 2'b11, 9'h021, 16'h0002);
        op(1, 2'b11, 9'h022, 16'h0003);
        @(negedge CLK);
        p1_we = 2'b00; p1_addr = 9'h020; p1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("b2b_rvalid", {31'd0, p1_rvalid}, 32'd1);
            chk("b2b_rdata",  {16'd0, p1_rdata},  i + 1);
            if (i < 2) p1_addr = 9'h021 + 9'(i);
            else       p1_valid = 1'b0;
        end
        @(posedge CLK); #1;
        chk("b2b_end_rvalid", {31'd0, p1_rvalid}, 32'd0);

        // Contention for 4 cycles (last grant so far: port 1)
        op(1, 2'b11, 9'h001, 16'h1111);
        op(1, 2'b11, 9'h002, 16'h2222);
        @(negedge CLK);
        p0_we = 2'b00; p0_addr = 9'h001; p0_valid = 1'b1;
        p1_we = 2'b00; p1_addr = 9'h002; p1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp0 = rr_mode ? ((i % 2) == 0) : 1'b1;
            chk("cont_p0_ready", {31'd0, p0_ready}, {31'd0, exp0});
            chk("cont_p1_ready", {31'd0, p1_ready}, {31'd0, ~exp0});
            @(posedge CLK); #1;
            chk("cont_p0_rvalid", {31'd0, p0_rvalid}, {31'd0, exp0});
            chk("cont_p1_rvalid", {31'd0, p1_rvalid}, {31'd0, ~exp0});
            if (exp0) chk("cont_p0_rdata", {16'd0, p0_rdata}, 32'h1111);
            else      chk("cont_p1_rdata", {16'd0, p1_rdata}, 32'h2222);
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;

        // Write on p0 and read on p1 of 0x030 together; p0 must go first
        @(negedge CLK);
        p0_we = 2'b11; p0_addr = 9'h030; p0_wdata = 16'h5555; p0_valid = 1'b1;
        p1_we = 2'b00; p1_addr = 9'h030; p1_valid = 1'b1;
        #1;
        chk("wr_rd_p0_first", {31'd0, p0_ready}, 32'd1);
        chk("wr_rd_p1_wait",  {31'd0, p1_ready}, 32'd0);
        @(posedge CLK); #1;
        p0_valid = 1'b0;
        #1;
        chk("wr_rd_p1_next", {31'd0, p1_ready}, 32'd1);
        @(posedge CLK); #1;
        p1_valid = 1'b0;
        chk("wr_rd_rvalid", {31'd0, p1_rvalid}, 32'd1);
        chk("wr_rd_rdata",  {16'd0, p1_rdata},  32'h5555);

        // Reset pulse while a read is pending
        @(negedge CLK);
        p0_we = 2'b00; p0_addr = 9'h010; p0_valid = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst2_ready",     {31'd0, p0_ready},  32'd0);
        chk("rst2_init_done", {31'd0, init_done}, 32'd0);
        chk("rst2_rdata",     {16'd0, p0_rdata},  32'h0000);
        @(posedge CLK); #1;
        chk("rst2_no_rvalid", {31'd0, p0_rvalid}, 32'd0);
        @(negedge CLK);
        p0_valid = 1'b0;
        RST_N = 1'b1;
        wait_init(cyc);
        chk("init2_latency", cyc, 32'd513);
        op(0, 2'b00, 9'h010, 16'h0000);
        chk("clr010_rvalid", {31'd0, p0_rvalid}, 32'd1);
        chk("clr010_rdata",  {16'd0, p0_rdata},  32'h0000);
        op(1, 2'b00, 9'h030, 16'h0000);
        chk("clr030_rdata",  {16'd0, p1_rdata},  32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_blockram_port_arbiter

// File: doc/blockram_port_arbiter.md
BLOCKRAM_PORT_ARBITER -- requirements
Module: blockram_port_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 512, meaning RAM depth in words.
REQ-002 SHALL have parameter ADD_WIDTH, default 9, meaning address width.
REQ-003 SHALL have parameter DI_WIDTH, default 8, meaning byte-lane width; word width is 2*DI_WIDTH.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have, for each n in {0,1}, port pn_valid  input  1  request present on port n.
REQ-007 SHALL have pn_ready  output  1  request on port n accepted this cycle.
REQ-008 SHALL have pn_we  input  2  byte write enables; bit1 = high lane, bit0 = low lane; 2'b00 = read.
REQ-009 SHALL have pn_addr  input  ADD_WIDTH  word address.
REQ-010 SHALL have pn_wdata  input  2*DI_WIDTH  write data.
REQ-011 SHALL have pn_rvalid  output  1  read data valid on port n.
REQ-012 SHALL have pn_rdata  output  2*DI_WIDTH  read data for port n.
REQ-013 SHALL have init_done  output  1  high once power-up clear has completed.

Function
REQ-014 SHALL implement two states: INIT (clear memory) and RUN (arbitrate requests).
REQ-015 In INIT, SHALL write all-zero to address cnt with both lanes enabled, cnt stepping 0..SIZE-1 one per cycle; both pn_ready SHALL be low.
REQ-016 After the write to SIZE-1, SHALL enter RUN and assert init_done from the next cycle; init_done SHALL remain high until reset.
REQ-017 In RUN, SHALL grant at most one port per cycle; pn_ready SHALL be a combinational function of pn_valid and the arbitration state.
REQ-018 A transfer on port n SHALL occur when pn_valid and pn_ready are both high; requesters hold their fields stable until accepted.
REQ-019 Accepted write SHALL update only the lanes whose pn_we bit is set; unselected lanes SHALL keep their stored value.
REQ-020 Accepted write SHALL produce no pn_rvalid; RAM output register SHALL hold its value (no-change mode).
REQ-021 Accepted read SHALL assert pn_rvalid for exactly one cycle, one cycle after acceptance, with pn_rdata equal to the stored word.
REQ-022 pn_rdata SHALL hold its last value while pn_rvalid is low.
REQ-023 Back-to-back accepted reads SHALL produce one-per-cycle responses with no bubble.
REQ-024 Write then read of the same address on consecutive accepted cycles SHALL return the newly written data.
REQ-025 With only one port valid, SHALL grant that port in the same cycle.

Reset
REQ-026 On RST_N low, SHALL enter INIT, clear cnt to 0, and drive pn_ready=0, pn_rvalid=0, pn_rdata=0, init_done=0; last-grant register SHALL be reset to port 1.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from address 0; any response in flight SHALL be dropped.

Configuration
REQ-028 With macro BRAM_ARB_ROUND_ROBIN_EN defined, when both ports are valid, SHALL grant the port not granted last; last-grant SHALL update only on an accepted transfer.
REQ-029 Without BRAM_ARB_ROUND_ROBIN_EN, when both ports are valid, SHALL always grant port 0, and the last-grant register SHALL be absent.

Structure
REQ-030 SHALL place the state encoding (ST_INIT, ST_RUN) and port-index constants in shared package bram_pkg.
REQ-031 SHALL instantiate the storage as sub-module bram_sp_bytewe: single port, 2-lane byte write enable, registered output, no-change mode.

Verification
REQ-032 Reset, then count cycles -> init_done rises exactly SIZE+1 cycles after RST_N deasserts (513 at default); reads of 0x000 and 0x1FF return 0x0000.
REQ-033 p0 writes 0x1234 with we=11 to 0x010, then we=01 with 0xABCD, then reads -> p0_rvalid one cycle after the read is accepted, p0_rdata=0x12CD.
REQ-034 Both ports valid for 4 cycles, reading addresses 0x001/0x002, with macro defined -> grants alternate 0,1,0,1; without macro -> p0 granted all 4 and p1_ready stays 0.
REQ-035 p1 reads 0x020, 0x021, 0x022 back-to-back with stored values 1,2,3 -> p1_rvalid high 3 consecutive cycles, data 0x0001, 0x0002, 0x0003.
REQ-036 RST_N pulsed low during a RUN read -> no pn_rvalid follows, init_done drops, and the RAM clears again (previously written 0x010 reads 0x0000).
REQ-037 p0 write 0x5555 and p1 read of the same address 0x030 both valid, macro defined, p1 last granted -> p0 granted first; p1 read returns 0x5555.
